// File: rtl/obstacle_generator.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_generator
// Purpose  : Owns SLOT_COUNT obstacle slots for the game-logic stage. Spawns
//            obstacles at the right screen edge using a 16-bit Galois LFSR,
//            scrolls them left at a speed that ramps up over play time, and
//            retires them once they leave the screen. Runs on the frame clock.
// Ports    : clk              - frame clock (60 Hz)
//            rst_n            - asynchronous active-low reset
//            gamemode         - 00 restart, 01 play, 10 pause, 11 crashed
//            obstacle_x_left  - left edge per slot   [SLOT_COUNT-1:0][9:0]
//            obstacle_x_right - right edge per slot  [SLOT_COUNT-1:0][9:0]
//            obstacle_y_up    - top edge per slot    [SLOT_COUNT-1:0][8:0]
//            obstacle_y_down  - bottom edge per slot [SLOT_COUNT-1:0][8:0]
//            obstacle_active  - slot-valid flags
//            scroll_speed     - current scroll speed, pixels per frame
//            score            - retired-obstacle count, saturating
// Options  : OBSTACLE_GAP_PAIR_EN - when defined, every spawn emits a
//            top/bottom pair leaving a GAP_HEIGHT-pixel gap between them.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_generator #(
  parameter int          SLOT_COUNT        = 10,
  parameter int          SCREEN_W          = 640,
  parameter int          OBST_WIDTH        = 40,
  parameter int          UPPER_BOUND       = 20,
  parameter int          LOWER_BOUND       = 460,
  parameter int          MIN_HEIGHT        = 60,
  parameter int          SPAWN_INTERVAL    = 90,
  parameter int          BASE_SPEED        = 4,
  parameter int          MAX_SPEED         = 8,
  parameter int          SPEED_STEP_FRAMES = 600,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 gamemode,
  output logic [SLOT_COUNT-1:0][9:0] obstacle_x_left,
  output logic [SLOT_COUNT-1:0][9:0] obstacle_x_right,
  output logic [SLOT_COUNT-1:0][8:0] obstacle_y_up,
  output logic [SLOT_COUNT-1:0][8:0] obstacle_y_down,
  output logic [SLOT_COUNT-1:0]      obstacle_active,
  output logic [3:0]                 scroll_speed,
  output logic [15:0]                score
);

  localparam int c_spawn_tw = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int c_speed_tw = (SPEED_STEP_FRAMES > 1) ? $clog2(SPEED_STEP_FRAMES) : 1;
  localparam int c_idx_w    = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
  localparam int c_cnt_w    = $clog2(SLOT_COUNT + 1);

  localparam logic [c_spawn_tw-1:0] c_spawn_last = c_spawn_tw'(SPAWN_INTERVAL - 1);
  localparam logic [c_speed_tw-1:0] c_speed_last = c_speed_tw'(SPEED_STEP_FRAMES - 1);
  localparam logic [9:0]            c_spawn_xl   = 10'(SCREEN_W);
  localparam logic [9:0]            c_spawn_xr   = 10'(SCREEN_W + OBST_WIDTH);
  localparam logic [3:0]            c_base_speed = 4'(BASE_SPEED);
  localparam logic [3:0]            c_max_speed  = 4'(MAX_SPEED);
  localparam logic [1:0]            c_gm_restart = 2'b00;
  localparam logic [1:0]            c_gm_play    = 2'b01;

`ifdef OBSTACLE_GAP_PAIR_EN
  localparam int         GAP_HEIGHT = 140;
  localparam logic [10:0] c_gap_base = 11'(UPPER_BOUND + 40);
  localparam logic [10:0] c_gap_cap  = 11'(LOWER_BOUND - 40 - GAP_HEIGHT);
`endif

  // Galois form, taps 16,14,13,11 (mask 16'hB400), shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [15:0]                 lfsr_q, lfsr_d;
  logic [SLOT_COUNT-1:0]       active_q, active_d;
  logic [SLOT_COUNT-1:0][9:0]  x_left_q, x_left_d;
  logic [SLOT_COUNT-1:0][9:0]  x_right_q, x_right_d;
  logic [SLOT_COUNT-1:0][8:0]  y_up_q, y_up_d;
  logic [SLOT_COUNT-1:0][8:0]  y_down_q, y_down_d;
  logic [3:0]                  speed_q, speed_d;
  logic [15:0]                 score_q, score_d;
  logic [c_spawn_tw-1:0]       spawn_timer_q, spawn_timer_d;
  logic [c_speed_tw-1:0]       speed_timer_q, speed_timer_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                        free_found_0;
  logic [c_idx_w-1:0]          free_idx_0;
  logic [8:0]                  spawn_y_up_a, spawn_y_down_a;
  logic [c_cnt_w-1:0]          retire_cnt;
  logic [16:0]                 score_sum;
`ifdef OBSTACLE_GAP_PAIR_EN
  logic                        free_found_1;
  logic [c_idx_w-1:0]          free_idx_1;
  logic [8:0]                  spawn_y_up_b, spawn_y_down_b;
  logic [10:0]                 gap_raw, gap_top;
`else
  logic [10:0]                 height;
`endif

  // Free slots are judged on pre-edge activity only, so a slot retiring on
  // this edge cannot be refilled until the following edge.
  always_comb begin : free_search
    free_found_0 = 1'b0;
    free_idx_0   = '0;
`ifdef OBSTACLE_GAP_PAIR_EN
    free_found_1 = 1'b0;
    free_idx_1   = '0;
`endif
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (!active_q[i]) begin
        if (!free_found_0) begin
          free_found_0 = 1'b1;
          free_idx_0   = c_idx_w'(i);
        end
`ifdef OBSTACLE_GAP_PAIR_EN
        else if (!free_found_1) begin
          free_found_1 = 1'b1;
          free_idx_1   = c_idx_w'(i);
        end
`endif
      end
    end
  end

  // Vertical geometry of a new spawn, taken from the pre-edge LFSR value.
  always_comb begin : spawn_geometry
`ifdef OBSTACLE_GAP_PAIR_EN
    gap_raw        = c_gap_base + {3'b000, lfsr_q[7:0]};
    gap_top        = (gap_raw > c_gap_cap) ? c_gap_cap : gap_raw;
    spawn_y_up_a   = 9'(UPPER_BOUND);
    spawn_y_down_a = 9'(gap_top);
    spawn_y_up_b   = 9'(gap_top + 11'(GAP_HEIGHT));
    spawn_y_down_b = 9'(LOWER_BOUND);
`else
    height = 11'(MIN_HEIGHT) + {4'b0000, lfsr_q[6:0]};
    if (lfsr_q[15]) begin
      spawn_y_up_a   = 9'(11'(LOWER_BOUND) - height);
      spawn_y_down_a = 9'(LOWER_BOUND);
    end else begin
      spawn_y_up_a   = 9'(UPPER_BOUND);
      spawn_y_down_a = 9'(11'(UPPER_BOUND) + height);
    end
`endif
  end

  always_comb begin : next_state
    lfsr_d        = lfsr_step(lfsr_q);
    active_d      = active_q;
    x_left_d      = x_left_q;
    x_right_d     = x_right_q;
    y_up_d        = y_up_q;
    y_down_d      = y_down_q;
    speed_d       = speed_q;
    score_d       = score_q;
    spawn_timer_d = spawn_timer_q;
    speed_timer_d = speed_timer_q;
    retire_cnt    = '0;
    score_sum     = '0;

    case (gamemode)
      c_gm_restart: begin
        active_d      = '0;
        x_left_d      = '0;
        x_right_d     = '0;
        y_up_d        = '0;
        y_down_d      = '0;
        speed_d       = c_base_speed;
        score_d       = '0;
        spawn_timer_d = '0;
        speed_timer_d = '0;
      end

      c_gm_play: begin
        // Scroll or retire every slot that was live before this edge.
        for (int i = 0; i < SLOT_COUNT; i++) begin
          if (active_q[i]) begin
            if ({1'b0, x_right_q[i]} <= {7'b0000000, speed_q}) begin
              active_d[i]  = 1'b0;
              x_left_d[i]  = '0;
              x_right_d[i] = '0;
              y_up_d[i]    = '0;
              y_down_d[i]  = '0;
              retire_cnt   = retire_cnt + c_cnt_w'(1);
            end else begin
              x_right_d[i] = 10'({1'b0, x_right_q[i]} - {7'b0000000, speed_q});
              x_left_d[i]  = (x_left_q[i] > {6'b000000, speed_q})
                           ? x_left_q[i] - {6'b000000, speed_q} : 10'd0;
            end
          end
        end

        score_sum = {1'b0, score_q} + 17'(retire_cnt);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        // When the interval has elapsed but no slot is free, the timer
        // parks at its last value so a spawn is retried every edge.
        if (spawn_timer_q == c_spawn_last) begin
`ifdef OBSTACLE_GAP_PAIR_EN
          if (free_found_1) begin
            active_d[free_idx_0]  = 1'b1;
            x_left_d[free_idx_0]  = c_spawn_xl;
            x_right_d[free_idx_0] = c_spawn_xr;
            y_up_d[free_idx_0]    = spawn_y_up_a;
            y_down_d[free_idx_0]  = spawn_y_down_a;
            active_d[free_idx_1]  = 1'b1;
            x_left_d[free_idx_1]  = c_spawn_xl;
            x_right_d[free_idx_1] = c_spawn_xr;
            y_up_d[free_idx_1]    = spawn_y_up_b;
            y_down_d[free_idx_1]  = spawn_y_down_b;
            spawn_timer_d         = '0;
          end
`else
          if (free_found_0) begin
            active_d[free_idx_0]  = 1'b1;
            x_left_d[free_idx_0]  = c_spawn_xl;
            x_right_d[free_idx_0] = c_spawn_xr;
            y_up_d[free_idx_0]    = spawn_y_up_a;
            y_down_d[free_idx_0]  = spawn_y_down_a;
            spawn_timer_d         = '0;
          end
`endif
        end else begin
          spawn_timer_d = spawn_timer_q + c_spawn_tw'(1);
        end

        // Speed ramp; the new speed is only seen by the next edge's scroll.
        if (speed_timer_q == c_speed_last) begin
          speed_timer_d = '0;
          if (speed_q < c_max_speed) begin
            speed_d = speed_q + 4'd1;
          end
        end else begin
          speed_timer_d = speed_timer_q + c_speed_tw'(1);
        end
      end

      default: begin
        // Pause / crashed: everything but the LFSR holds.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q        <= LFSR_SEED;
      active_q      <= '0;
      x_left_q      <= '0;
      x_right_q     <= '0;
      y_up_q        <= '0;
      y_down_q      <= '0;
      speed_q       <= c_base_speed;
      score_q       <= '0;
      spawn_timer_q <= '0;
      speed_timer_q <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      active_q      <= active_d;
      x_left_q      <= x_left_d;
      x_right_q     <= x_right_d;
      y_up_q        <= y_up_d;
      y_down_q      <= y_down_d;
      speed_q       <= speed_d;
      score_q       <= score_d;
      spawn_timer_q <= spawn_timer_d;
      speed_timer_q <= speed_timer_d;
    end
  end

  assign obstacle_x_left  = x_left_q;
  assign obstacle_x_right = x_right_q;
  assign obstacle_y_up    = y_up_q;
  assign obstacle_y_down  = y_down_q;
  assign obstacle_active  = active_q;
  assign scroll_speed     = speed_q;
  assign score            = score_q;

endmodule
`default_nettype wire
